rr_arb8: RTL and testbench
==========================

RR_ARB8 -- requirements
Module: rr_arb8

Interface
REQ-001 Parameter: MAX_HOLD, default 16, maximum consecutive grant cycles per holder (legal 1..255).
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 en  input  1  arbitration enable; low blocks new grants only.
REQ-005 req  input  8  request vector, bit i = requester i, level-sensitive.
REQ-006 gnt_idx  output  3  binary index of current holder.
REQ-007 gnt_valid  output  1  high while a grant is active.
REQ-008 gnt  output  8  one-hot grant: decode of gnt_idx when gnt_valid, else all zero.

Function
REQ-009 FSM states SHALL be IDLE and GRANT only.
REQ-010 Round-robin pointer ptr (3 bits) SHALL hold the index of the last holder; search order is ptr+1, ptr+2 ... ptr (mod 8 wrap).
REQ-011 IDLE: if en=1 and req!=0 at a rising edge, SHALL enter GRANT with gnt_idx = first set req bit in search order, gnt_valid=1, hold_cnt=0 (one-cycle latency req->gnt).
REQ-012 IDLE with en=0 or req=0 SHALL remain IDLE, outputs unchanged from idle values.
REQ-013 GRANT: hold_cnt SHALL increment each cycle while req[gnt_idx]=1 and hold_cnt<MAX_HOLD-1.
REQ-014 Release SHALL occur at the edge where req[gnt_idx]=0 (drop) or hold_cnt=MAX_HOLD-1 (expiry).
REQ-015 On release, ptr SHALL load gnt_idx.
REQ-016 On release with en=1 and any req bit set, SHALL grant next requester in new search order on the same edge (no idle bubble), hold_cnt=0.
REQ-017 On expiry, if holder is the only requester, SHALL re-grant the same index with hold_cnt=0.
REQ-018 On release with en=0 or req=0, SHALL enter IDLE, gnt_valid=0; gnt_idx retains last value.
REQ-019 en=0 during GRANT SHALL NOT revoke the current grant; only the next grant is suppressed.
REQ-020 Requests asserted/dropped by non-holders during GRANT SHALL have no effect until release.
REQ-021 gnt SHALL have exactly one bit set when gnt_valid=1 and SHALL equal zero otherwise; never more than one bit.
REQ-022 hold_cnt SHALL be 8 bits and never exceed MAX_HOLD-1.

Reset
REQ-023 rst_n low SHALL immediately force IDLE, gnt_valid=0, gnt_idx=0, gnt=0, hold_cnt=0, ptr=7 (first search starts at index 0).
REQ-024 Reset asserted mid-grant SHALL drop the grant without waiting for a clock edge; first grant after release follows REQ-011.

Structure
REQ-025 A shared package SHALL hold the FSM state encoding and the constants NUM_REQ=8 and IDX_W=3.
REQ-026 gnt SHALL be produced by one instance of the team's 3-to-8 one-hot decoder sub-module decoder_38 on gnt_idx, gated by gnt_valid.
REQ-027 Priority search SHALL be combinational; all state (FSM, ptr, hold_cnt, gnt_idx, gnt_valid) registered.

Verification
REQ-028 Reset then req=8'b0000_0001, en=1 -> gnt=8'h01, gnt_valid=1 one cycle later; gnt_idx=0.
REQ-029 req=8'hFF held, MAX_HOLD=4 -> grants rotate 0,1,2,...,7,0, each exactly 4 cycles, no bubble cycles.
REQ-030 Holder 2 drops req while req[5]=1 -> next edge gnt_idx=5, gnt=8'h20; ptr=2.
REQ-031 Only req[3]=1 held, MAX_HOLD=4 -> gnt_idx stays 3, gnt_valid stays 1, hold_cnt cycles 0..3 repeatedly.
REQ-032 en=0 during grant to 6, holder drops req, req[1]=1 -> IDLE, gnt=0; en=1 -> gnt_idx=1 next edge.
REQ-033 rst_n pulsed low mid-grant between clock edges -> gnt=0 and gnt_valid=0 immediately; ptr=7 after release.

Source files
------------

// File: rtl/rr_arb8_pkg.sv
// Shared constants, FSM encoding and round-robin search helper for the
// eight-way round-robin arbiter.
package rr_arb8_pkg;

   localparam int NUM_REQ = 8;
   localparam int IDX_W   = 3;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_e;

   // First set request bit scanning base+1, base+2 ... base (wrapping).
   // Descending scan lets the nearest position overwrite farther ones.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                input logic [IDX_W-1:0]   base);
      logic [IDX_W-1:0] idx;
      rr_pick = base;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = base + IDX_W'(k);
         if (req[idx]) rr_pick = idx;
      end
   endfunction

endpackage

// File: rtl/rr_arb8_decoder_38.sv
// 3-to-8 one-hot decoder with enable; all outputs low when disabled.
module decoder_38
   import rr_arb8_pkg::*;
(
   input  logic               en,
   input  logic [IDX_W-1:0]   idx,
   output logic [NUM_REQ-1:0] dec
);

   always_comb begin
      dec = '0;
      if (en) dec[idx] = 1'b1;
   end

endmodule

// File: rtl/rr_arb8.sv
// Eight-requester round-robin arbiter with a bounded per-holder grant time
// and back-to-back handover on release.
module rr_arb8
   import rr_arb8_pkg::*;
#(
   parameter int MAX_HOLD = 16
)
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic [NUM_REQ-1:0] req,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               gnt_valid,
   output logic [NUM_REQ-1:0] gnt
);

   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
   logic [7:0]         hold_cnt_q, hold_cnt_d;
   logic               gnt_valid_q, gnt_valid_d;

   logic [IDX_W-1:0]   search_base;
   logic [IDX_W-1:0]   pick_idx;
   logic               any_req;
   logic               release_c;

   // On release ptr becomes the old holder, so the search can start from
   // gnt_idx directly and still hand over on the same edge.
   always_comb begin
      search_base = (state_q == ST_GRANT) ? gnt_idx_q : ptr_q;
      pick_idx    = rr_pick(req, search_base);
      any_req     = |req;
      release_c   = (state_q == ST_GRANT) &&
                    (!req[gnt_idx_q] || (hold_cnt_q == HOLD_LAST));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '1;
         gnt_idx_q   <= '0;
         hold_cnt_q  <= '0;
         gnt_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         gnt_idx_q   <= gnt_idx_d;
         hold_cnt_q  <= hold_cnt_d;
         gnt_valid_q <= gnt_valid_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      gnt_idx_d   = gnt_idx_q;
      hold_cnt_d  = hold_cnt_q;
      gnt_valid_d = gnt_valid_q;
      case (state_q)
         ST_IDLE: begin
            if (en && any_req) begin
               state_d     = ST_GRANT;
               gnt_idx_d   = pick_idx;
               hold_cnt_d  = '0;
               gnt_valid_d = 1'b1;
            end
         end
         ST_GRANT: begin
            if (!release_c) begin
               hold_cnt_d = hold_cnt_q + 8'd1;
            end else begin
               ptr_d      = gnt_idx_q;
               hold_cnt_d = '0;
               if (en && any_req) begin
                  gnt_idx_d = pick_idx;
               end else begin
                  state_d     = ST_IDLE;
                  gnt_valid_d = 1'b0;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      gnt_idx   = gnt_idx_q;
      gnt_valid = gnt_valid_q;
   end

   decoder_38 u_dec (
      .en  (gnt_valid_q),
      .idx (gnt_idx_q),
      .dec (gnt)
   );

endmodule

// File: tb/tb_rr_arb8.sv
// Directed bench for rr_arb8 (MAX_HOLD=4) with a per-cycle reference model.
`timescale 1ns/100ps
module tb_rr_arb8;

   localparam int MAXH = 4;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [7:0] req;
   logic [2:0] gnt_idx;
   logic       gnt_valid;
   logic [7:0] gnt;

   int n_cmp  = 0;
   int n_fail = 0;
   bit run    = 0;

   // Reference model state: who holds, for how many cycles, last holder.
   int m_holder, m_cnt, m_ptr;
   bit m_valid;

   rr_arb8 #(.MAX_HOLD(MAXH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .req       (req),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid),
      .gnt       (gnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int next_req(input int from, input logic [7:0] r);
      for (int k = 1; k <= 8; k++) begin
         if (r[(from + k) % 8]) return (from + k) % 8;
      end
      return -1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      int h, c, p;
      bit v;
      if (!rst_n) begin
         m_holder <= 0;
         m_cnt    <= 0;
         m_ptr    <= 7;
         m_valid  <= 1'b0;
      end else begin
         h = m_holder; c = m_cnt; p = m_ptr; v = m_valid;
         if (!v) begin
            if (en && req != 8'h00) begin
               h = next_req(p, req); c = 0; v = 1'b1;
            end
         end else if (req[h] && c < MAXH - 1) begin
            c = c + 1;
         end else begin
            p = h;
            c = 0;
            if (en && req != 8'h00) h = next_req(p, req);
            else v = 1'b0;
         end
         m_holder <= h; m_cnt <= c; m_ptr <= p; m_valid <= v;
      end
   end

   always @(negedge clk) begin
      if (run && rst_n) begin
         check("m_valid", int'(gnt_valid), int'(m_valid));
         check("m_idx", int'(gnt_idx), m_holder);
         check("m_gnt", int'(gnt), m_valid ? (1 << m_holder) : 0);
         check("m_hold", int'(dut.hold_cnt_q), m_cnt);
         check("m_ptr", int'(dut.ptr_q), m_ptr);
      end
   end

   // Apply inputs for exactly one rising edge; returns 2ns after that edge.
   task automatic cyc(input logic e, input logic [7:0] r);
      en  = e;
      req = r;
      @(posedge clk);
      #2;
   endtask

   initial begin
      rst_n = 1'b0;
      en    = 1'b0;
      req   = 8'h00;
      repeat (2) @(posedge clk);
      #2;
      check("rst_valid", int'(gnt_valid), 0);
      check("rst_idx", int'(gnt_idx), 0);
      check("rst_gnt", int'(gnt), 0);
      check("rst_ptr", int'(dut.ptr_q), 7);
      check("rst_hold", int'(dut.hold_cnt_q), 0);
      rst_n = 1'b1;
      run   = 1'b1;

      // First grant one edge after request
      cyc(1'b1, 8'h01);
      check("first_gnt", int'(gnt), 8'h01);
      check("first_valid", int'(gnt_valid), 1);
      check("first_idx", int'(gnt_idx), 0);
      cyc(1'b1, 8'h00);
      check("idle_valid", int'(gnt_valid), 0);
      check("idle_gnt", int'(gnt), 0);
      check("idle_idx_kept", int'(gnt_idx), 0);

      // Holder 2 drops while 5 waits
      cyc(1'b1, 8'h04);
      check("h2_idx", int'(gnt_idx), 2);
      cyc(1'b1, 8'h24);
      cyc(1'b1, 8'h2C);
      check("h2_nonholder_ignored", int'(gnt_idx), 2);
      cyc(1'b1, 8'h20);
      check("h5_idx", int'(gnt_idx), 5);
      check("h5_gnt", int'(gnt), 8'h20);
      check("h5_ptr", int'(dut.ptr_q), 2);

      // en low does not revoke, but suppresses the next grant
      cyc(1'b1, 8'h40);
      check("h6_idx", int'(gnt_idx), 6);
      cyc(1'b0, 8'h40);
      check("h6_kept_en0", int'(gnt_valid), 1);
      cyc(1'b0, 8'h02);
      check("en0_idle_gnt", int'(gnt), 0);
      check("en0_idle_valid", int'(gnt_valid), 0);
      cyc(1'b0, 8'h02);
      check("en0_stay_idle", int'(gnt_valid), 0);
      cyc(1'b1, 8'h02);
      check("en1_idx", int'(gnt_idx), 1);
      check("en1_gnt", int'(gnt), 8'h02);

      // Lone requester re-granted on expiry
      cyc(1'b1, 8'h08);
      check("lone_idx", int'(gnt_idx), 3);
      for (int k = 1; k <= 8; k++) begin
         cyc(1'b1, 8'h08);
         check("lone_hold", int'(dut.hold_cnt_q), k % 4);
         check("lone_idx_kept", int'(gnt_idx), 3);
         check("lone_valid", int'(gnt_valid), 1);
      end

      // Asynchronous reset between edges
      rst_n = 1'b0;
      #1;
      check("arst_gnt", int'(gnt), 0);
      check("arst_valid", int'(gnt_valid), 0);
      check("arst_idx", int'(gnt_idx), 0);
      rst_n = 1'b1;
      #1;
      check("arst_ptr", int'(dut.ptr_q), 7);
      cyc(1'b1, 8'h08);
      check("post_arst_idx", int'(gnt_idx), 3);

      // Full rotation from a fresh reset, 4 cycles per holder
      en    = 1'b0;
      req   = 8'h00;
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      cyc(1'b1, 8'hFF);
      check("rot_start", int'(gnt_idx), 0);
      for (int k = 1; k <= 32; k++) begin
         cyc(1'b1, 8'hFF);
         check("rot_idx", int'(gnt_idx), (k / 4) % 8);
         check("rot_valid", int'(gnt_valid), 1);
      end

      cyc(1'b1, 8'h00);
      @(negedge clk);
      run = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
